// File: rtl/matmul_result_writer.sv
// rtl/matmul_result_writer.sv - captures a matmul result vector and streams the active sub-matrix to the ScratchPad
module matmul_result_writer #(
  parameter int DATA_WIDTH  = 16,
  parameter int BUS_WIDTH   = 64,
  parameter int ADDR_WIDTH  = 16,
  parameter int SP_NTARGETS = 4,
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH,
  localparam int DW = ($clog2(MAX_DIM) > 1) ? $clog2(MAX_DIM) : 1,
  localparam int TW = ($clog2(SP_NTARGETS) > 1) ? $clog2(SP_NTARGETS) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 start_i,
  input  logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0] res_i,
  input  logic [MAX_DIM*MAX_DIM-1:0]           flags_i,
  input  logic [DW-1:0]                        dim_n_i,
  input  logic [DW-1:0]                        dim_p_i,
  input  logic [TW-1:0]                        target_i,
  output logic                                 busy_o,
  output logic                                 sp_wr_valid_o,
  input  logic                                 sp_wr_ready_i,
  output logic [ADDR_WIDTH-1:0]                sp_wr_addr_o,
  output logic [BUS_WIDTH-1:0]                 sp_wr_data_o,
  output logic                                 done_o,
  output logic [MAX_DIM*MAX_DIM-1:0]           flags_o,
  output logic                                 overflow_o
);

  localparam int NE = MAX_DIM * MAX_DIM;
  localparam int IW = ($clog2(NE) > 1) ? $clog2(NE) : 1;
  localparam int EW = ADDR_WIDTH + TW + IW + 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]                   state_q, state_d;
  logic [NE-1:0][BUS_WIDTH-1:0] res_q, res_d;
  logic [DW-1:0]                dim_n_q, dim_n_d;
  logic [DW-1:0]                dim_p_q, dim_p_d;
  logic [DW-1:0]                row_q, row_d;
  logic [DW-1:0]                col_q, col_d;
  logic [TW-1:0]                target_q, target_d;
  logic [NE-1:0]                flags_q, flags_d;
  logic [NE-1:0]                flags_mask;
  logic                         overflow_q, overflow_d;
  logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic [BUS_WIDTH-1:0]         data_q, data_d;
  logic                         last_beat;

  // Address is computed wide, then truncated or zero-extended to the port width.
  function automatic logic [ADDR_WIDTH-1:0] sp_addr(input logic [TW-1:0] tgt,
                                                    input logic [DW-1:0] row,
                                                    input logic [DW-1:0] col);
    logic [EW-1:0] full;
    full = EW'(tgt) * EW'(NE) + EW'(row) * EW'(MAX_DIM) + EW'(col);
    return full[ADDR_WIDTH-1:0];
  endfunction

  function automatic logic [IW-1:0] elem_idx(input logic [DW-1:0] row,
                                             input logic [DW-1:0] col);
    return IW'(row) * IW'(MAX_DIM) + IW'(col);
  endfunction

  always_comb begin
    for (int k = 0; k < NE; k++) begin
      flags_mask[k] = flags_i[k] && ((k / MAX_DIM) <= int'(dim_n_i))
                                 && ((k % MAX_DIM) <= int'(dim_p_i));
    end
  end

  assign last_beat = (row_q == dim_n_q) && (col_q == dim_p_q);

  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    dim_n_d    = dim_n_q;
    dim_p_d    = dim_p_q;
    target_d   = target_q;
    row_d      = row_q;
    col_d      = col_q;
    flags_d    = flags_q;
    overflow_d = overflow_q;
    addr_d     = addr_q;
    data_d     = data_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_WRITE;
          res_d      = res_i;
          dim_n_d    = dim_n_i;
          dim_p_d    = dim_p_i;
          target_d   = target_i;
          flags_d    = flags_mask;
          overflow_d = |flags_mask;
          row_d      = '0;
          col_d      = '0;
          addr_d     = sp_addr(target_i, '0, '0);
          data_d     = res_i[BUS_WIDTH-1:0];
        end
      end
      ST_WRITE: begin
        if (sp_wr_ready_i) begin
          if (last_beat) begin
            state_d = ST_DONE;
          end else begin
            // Column wraps at the active width so inactive elements are never visited.
            if (col_q == dim_p_q) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
            addr_d = sp_addr(target_q, row_d, col_d);
            data_d = res_q[elem_idx(row_d, col_d)];
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      res_q      <= '0;
      dim_n_q    <= '0;
      dim_p_q    <= '0;
      target_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      flags_q    <= '0;
      overflow_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      res_q      <= res_d;
      dim_n_q    <= dim_n_d;
      dim_p_q    <= dim_p_d;
      target_q   <= target_d;
      row_q      <= row_d;
      col_q      <= col_d;
      flags_q    <= flags_d;
      overflow_q <= overflow_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign sp_wr_valid_o = (state_q == ST_WRITE);
  assign done_o        = (state_q == ST_DONE);
  assign sp_wr_addr_o  = addr_q;
  assign sp_wr_data_o  = data_q;
  assign flags_o       = flags_q;
  assign overflow_o    = overflow_q;

endmodule

// File: doc/matmul_result_writer.md
Name: matmul_result_writer

Overview:
- Downstream of the result adder stage: captures the full MAX_DIM x MAX_DIM result vector and its per-element overflow flags in one cycle.
- Streams the active n x p sub-matrix element by element into the ScratchPad over a valid/ready write port.
- Holds the masked overflow flags for the control/status logic.
- Frees the adder/systolic array for the next operation as soon as capture is done.

Parameters:
- DATA_WIDTH, 16: operand element width in bits.
- BUS_WIDTH, 64: result element width and ScratchPad write-data width.
- ADDR_WIDTH, 16: ScratchPad address width.
- SP_NTARGETS, 4: number of matrix slots in the ScratchPad.
- MAX_DIM (localparam) = BUS_WIDTH/DATA_WIDTH.
- DW (localparam) = max(1, $clog2(MAX_DIM)).
- TW (localparam) = max(1, $clog2(SP_NTARGETS)).

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- start_i  in  1  single-cycle capture request.
- res_i  in  BUS_WIDTH*MAX_DIM**2  result vector; element k at [(k+1)*BUS_WIDTH-1 -: BUS_WIDTH].
- flags_i  in  MAX_DIM**2  per-element overflow flags, bit k pairs with element k.
- dim_n_i  in  DW  result rows minus 1.
- dim_p_i  in  DW  result columns minus 1.
- target_i  in  TW  destination ScratchPad slot.
- busy_o  out  1  high from capture until done.
- sp_wr_valid_o  out  1  write request.
- sp_wr_ready_i  in  1  ScratchPad accepts write.
- sp_wr_addr_o  out  ADDR_WIDTH  write address.
- sp_wr_data_o  out  BUS_WIDTH  write data.
- done_o  out  1  one-cycle completion pulse.
- flags_o  out  MAX_DIM**2  captured flags, masked to the active region.
- overflow_o  out  1  OR-reduction of flags_o.

Behaviour:
- Reset (async, rst_ni low): state IDLE, busy_o=0, sp_wr_valid_o=0, sp_wr_addr_o=0, sp_wr_data_o=0, done_o=0, flags_o=0, overflow_o=0, row/col counters 0.
- Reset mid-transfer aborts immediately. No further writes are issued and no done_o pulse is generated.
- IDLE: start_i=1 registers res_i, dims, target and masked flags in that cycle. Next state WRITE, busy_o=1 from the next cycle.
  - flags_o[k] = flags_i[k] & (k/MAX_DIM <= dim_n_i) & (k%MAX_DIM <= dim_p_i).
  - overflow_o updates in the same cycle as flags_o.
  - flags_o/overflow_o then hold until the next accepted start_i.
- WRITE: sp_wr_valid_o=1.
  - sp_wr_addr_o = target*MAX_DIM**2 + row*MAX_DIM + col, zero-extended or truncated to ADDR_WIDTH.
  - sp_wr_data_o = captured element (row*MAX_DIM + col).
  - Order is row-major, col fastest. Elements outside the active region are skipped, never written.
- Handshake:
  - A beat transfers when valid&ready are sampled high on a rising edge.
  - While ready=0, valid, addr and data hold stable.
  - No combinational path from sp_wr_ready_i to sp_wr_valid_o. Valid stays high through consecutive beats (one beat per cycle max).
- Counter advance on transfer:
  - col==dim_p: col<=0, row<=row+1.
  - Otherwise col<=col+1.
  - Transfer of (dim_n, dim_p) goes to DONE instead.
- DONE: sp_wr_valid_o=0, done_o=1 for exactly one cycle, busy_o=0 next cycle, return to IDLE.
- Total writes = (dim_n+1)*(dim_p+1), from 1 (1x1) to MAX_DIM**2. Minimum latency, start to done_o with ready tied high = writes+1 cycles.
- start_i while busy (WRITE or DONE) is ignored. Captured data and flags are not disturbed.
- start_i in the IDLE cycle right after DONE is accepted normally.
- Inputs res_i/flags_i may change freely after the capture cycle.

Test Plan:
- Full 4x4, target 2, ready=1, element k = k+1 -> 16 back-to-back writes, addr 32..47, data 1..16, done_o 17 cycles after start, flags_o=0.
- 2x3 (dim_n=1, dim_p=2), target 0 -> 6 writes, addrs 0,1,2,4,5,6, data elements 0,1,2,4,5,6; element 3 never written.
- Backpressure: 4x4 with ready toggling 1,0,0,1,... -> addr/data stable while ready=0, exactly 16 writes in order, no duplicates, done_o once.
- Flags masking: flags_i=16'hFFFF with a 2x2 region -> flags_o=16'h0033, overflow_o=1. flags_i=16'h8000 with a 2x2 region -> flags_o=0, overflow_o=0.
- start_i pulsed mid-WRITE with different res_i/target -> ignored; original sequence completes unchanged.
- rst_ni asserted after the 5th write of a 4x4 -> all outputs 0 asynchronously, no done_o; a new 1x1 start then gives a single write and done_o.
